// File: rtl/mult_batch_engine_pkg.sv
// Shared types and constants for the batch multiplier engine.
// Optional overflow reporting is enabled with MULT_BATCH_OVF_EN (see mult_batch_engine).
package mult_batch_pkg;

    localparam int LINE_BITS = 512;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_OUTPUT
    } t_mbe_state;

    // Wide enough for the largest possible lane count (DATA_LEN=1 on a 512-bit line).
    typedef logic [7:0] t_lane_idx;

    function automatic int lanes_f(input int data_len, input int line_bits = LINE_BITS);
        return line_bits / (2 * data_len);
    endfunction

endpackage

// File: rtl/mult_batch_engine_if.sv
// Line-in / line-out valid-ready bus between the CCI-P logic and the batch multiplier engine.
interface mult_batch_engine_if #(
    parameter int DATA_LEN  = 32,
    parameter int LINE_BITS = mult_batch_pkg::LINE_BITS
);
    import mult_batch_pkg::*;

    localparam int LANES = lanes_f(DATA_LEN, LINE_BITS);
    localparam int CNT_W = $clog2(LANES + 1);

    logic                 in_valid;
    logic                 in_ready;
    logic [LINE_BITS-1:0] in_data;
    logic [CNT_W-1:0]     in_count;
    logic                 out_valid;
    logic                 out_ready;
    logic [LINE_BITS-1:0] out_data;
    logic [CNT_W-1:0]     out_count;
    logic [LANES-1:0]     ovf_mask;

    modport master (
        output in_valid, in_data, in_count, out_ready,
        input  in_ready, out_valid, out_data, out_count, ovf_mask
    );

    modport slave (
        input  in_valid, in_data, in_count, out_ready,
        output in_ready, out_valid, out_data, out_count, ovf_mask
    );

endinterface

// File: rtl/mult_batch_engine_mult_pipe.sv
// PIPELINE_STAGE-deep registered multiplier with valid and lane-tag sideband.
// Only the valid chain is reset/flushed; data registers are don't-care while invalid.
module mult_pipe
    import mult_batch_pkg::*;
#(
    parameter int DATA_LEN       = 32,
    parameter int PROD_W         = 32,
    parameter int PIPELINE_STAGE = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush_i,
    input  logic                valid_i,
    input  t_lane_idx           tag_i,
    input  logic [DATA_LEN-1:0] a_i,
    input  logic [DATA_LEN-1:0] b_i,
    output logic                valid_o,
    output t_lane_idx           tag_o,
    output logic [PROD_W-1:0]   prod_o
);

    logic [PIPELINE_STAGE-1:0] vld_q;
    logic [PROD_W-1:0]         prod_q [PIPELINE_STAGE];
    t_lane_idx                 tag_q  [PIPELINE_STAGE];
    logic [PROD_W-1:0]         prod;

    // PROD_W of DATA_LEN keeps only the wrapped low half of the product.
    assign prod = PROD_W'(a_i) * PROD_W'(b_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else if (flush_i) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= valid_i;
            for (int s = 1; s < PIPELINE_STAGE; s++) begin
                vld_q[s] <= vld_q[s-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        prod_q[0] <= prod;
        tag_q[0]  <= tag_i;
        for (int s = 1; s < PIPELINE_STAGE; s++) begin
            prod_q[s] <= prod_q[s-1];
            tag_q[s]  <= tag_q[s-1];
        end
    end

    assign valid_o = vld_q[PIPELINE_STAGE-1];
    assign tag_o   = tag_q[PIPELINE_STAGE-1];
    assign prod_o  = prod_q[PIPELINE_STAGE-1];

endmodule

// File: rtl/mult_batch_engine.sv
// Batch multiplier engine: takes one line of operand pairs, issues them through mult_pipe, returns one result line.
// Define MULT_BATCH_OVF_EN to form full-width products and report per-lane overflow in ovf_mask.
module mult_batch_engine #(
    parameter int DATA_LEN       = 32,
    parameter int PIPELINE_STAGE = 2,
    parameter int ISSUE_INTERVAL = 1,
    parameter int LINE_BITS      = mult_batch_pkg::LINE_BITS
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              soft_clear,
    mult_batch_engine_if.slave bus,
    output logic              busy
);
    import mult_batch_pkg::*;

    localparam int LANES  = lanes_f(DATA_LEN, LINE_BITS);
    localparam int CNT_W  = $clog2(LANES + 1);
    localparam int INTV_W = (ISSUE_INTERVAL > 1) ? $clog2(ISSUE_INTERVAL) : 1;
`ifdef MULT_BATCH_OVF_EN
    localparam int PROD_W = 2 * DATA_LEN;
`else
    localparam int PROD_W = DATA_LEN;
`endif

    t_mbe_state           state_q, state_d;
    logic [LINE_BITS-1:0] data_q, data_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [CNT_W-1:0]     issue_q, issue_d;
    logic [CNT_W-1:0]     ret_q, ret_d;
    logic [INTV_W-1:0]    intv_q, intv_d;
    logic [DATA_LEN-1:0]  res_q [LANES];
    logic [DATA_LEN-1:0]  res_d [LANES];
    logic [LANES-1:0]     ovf_q, ovf_d;

    logic                 iss_valid;
    t_lane_idx            iss_tag;
    logic [DATA_LEN-1:0]  iss_a, iss_b;
    logic                 ret_valid;
    t_lane_idx            ret_tag;
    logic [PROD_W-1:0]    ret_prod;
    logic                 ret_ovf;
    logic [CNT_W-1:0]     cnt_clamped;
    logic [LINE_BITS-1:0] out_line;

`ifdef MULT_BATCH_OVF_EN
    assign ret_ovf = |ret_prod[PROD_W-1:DATA_LEN];
`else
    assign ret_ovf = 1'b0;
`endif

    assign cnt_clamped = (bus.in_count > CNT_W'(LANES)) ? CNT_W'(LANES) : bus.in_count;
    assign iss_tag     = t_lane_idx'(issue_q);

    always_comb begin
        iss_a = '0;
        iss_b = '0;
        for (int i = 0; i < LANES; i++) begin
            if (issue_q == CNT_W'(i)) begin
                iss_a = data_q[(2*i)*DATA_LEN +: DATA_LEN];
                iss_b = data_q[(2*i+1)*DATA_LEN +: DATA_LEN];
            end
        end
    end

    mult_pipe #(
        .DATA_LEN      (DATA_LEN),
        .PROD_W        (PROD_W),
        .PIPELINE_STAGE(PIPELINE_STAGE)
    ) u_pipe (
        .clk    (clk),
        .rst_n  (reset_n),
        .flush_i(soft_clear),
        .valid_i(iss_valid),
        .tag_i  (iss_tag),
        .a_i    (iss_a),
        .b_i    (iss_b),
        .valid_o(ret_valid),
        .tag_o  (ret_tag),
        .prod_o (ret_prod)
    );

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        count_d   = count_q;
        issue_d   = issue_q;
        ret_d     = ret_q;
        intv_d    = intv_q;
        res_d     = res_q;
        ovf_d     = ovf_q;
        iss_valid = 1'b0;

        // Early lanes can return while later ones are still being issued.
        if (ret_valid && (state_q == ST_ISSUE || state_q == ST_DRAIN)) begin
            for (int i = 0; i < LANES; i++) begin
                if (ret_tag == t_lane_idx'(i)) begin
                    res_d[i] = ret_prod[DATA_LEN-1:0];
                    ovf_d[i] = ret_ovf;
                end
            end
            ret_d = ret_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    data_d  = bus.in_data;
                    count_d = cnt_clamped;
                    issue_d = '0;
                    ret_d   = '0;
                    intv_d  = '0;
                    res_d   = '{default: '0};
                    ovf_d   = '0;
                    state_d = (cnt_clamped == '0) ? ST_OUTPUT : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (intv_q == '0) begin
                    iss_valid = 1'b1;
                    intv_d    = INTV_W'(ISSUE_INTERVAL - 1);
                    issue_d   = issue_q + CNT_W'(1);
                    if (issue_q == count_q - CNT_W'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end else begin
                    intv_d = intv_q - INTV_W'(1);
                end
            end
            ST_DRAIN: begin
                if (ret_d == count_q) begin
                    state_d = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (soft_clear) begin
            state_d   = ST_IDLE;
            count_d   = '0;
            issue_d   = '0;
            ret_d     = '0;
            intv_d    = '0;
            res_d     = '{default: '0};
            ovf_d     = '0;
            iss_valid = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            count_q <= '0;
            issue_q <= '0;
            ret_q   <= '0;
            intv_q  <= '0;
            res_q   <= '{default: '0};
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            count_q <= count_d;
            issue_q <= issue_d;
            ret_q   <= ret_d;
            intv_q  <= intv_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        out_line = '0;
        for (int i = 0; i < LANES; i++) begin
            out_line[i*DATA_LEN +: DATA_LEN] = res_q[i];
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_OUTPUT);
    assign bus.out_data  = out_line;
    assign bus.out_count = count_q;
    assign bus.ovf_mask  = ovf_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mult_batch_engine.sv
// Directed bench for mult_batch_engine: one instance at ISSUE_INTERVAL=1 and one at 2.
// ovf_mask expectation follows MULT_BATCH_OVF_EN.
module tb_mult_batch_engine;
    import mult_batch_pkg::*;

    localparam int DL = 32;

    logic clk = 1'b0;
    logic reset_n;
    logic softClear;
    logic busyA, busyB;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mult_batch_engine_if #(.DATA_LEN(DL)) busA ();
    mult_batch_engine_if #(.DATA_LEN(DL)) busB ();

    mult_batch_engine #(.DATA_LEN(DL), .PIPELINE_STAGE(2), .ISSUE_INTERVAL(1)) dutA (
        .clk       (clk),
        .reset_n   (reset_n),
        .soft_clear(softClear),
        .bus       (busA.slave),
        .busy      (busyA)
    );

    mult_batch_engine #(.DATA_LEN(DL), .PIPELINE_STAGE(2), .ISSUE_INTERVAL(2)) dutB (
        .clk       (clk),
        .reset_n   (reset_n),
        .soft_clear(softClear),
        .bus       (busB.slave),
        .busy      (busyB)
    );

    function automatic logic [511:0] putWord(logic [511:0] l, int slot, logic [31:0] w);
        l[slot*32 +: 32] = w;
        return l;
    endfunction

    task automatic checkOutput(input string tag, input logic [511:0] observed, input logic [511:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Presents one job, waits for the accept edge, then counts cycles until out_valid (bounded).
    task automatic applyStimulus(input bit useB, input logic [511:0] data, input logic [3:0] cnt, output int lat);
        if (useB) begin
            busB.in_data = data; busB.in_count = cnt; busB.in_valid = 1'b1;
        end else begin
            busA.in_data = data; busA.in_count = cnt; busA.in_valid = 1'b1;
        end
        @(posedge clk); #1;
        busA.in_valid = 1'b0;
        busB.in_valid = 1'b0;
        lat = 1;
        while (!(useB ? busB.out_valid : busA.out_valid) && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic retire();
        @(posedge clk); #1;
    endtask

    logic [511:0] line, line2, expLine;
    logic [31:0]  exp10 [8] = '{32'd10, 32'd20, 32'd30, 32'd40, 32'd50, 32'd60, 32'd70, 32'd80};
    logic [31:0]  exp9  [8] = '{32'd6, 32'd12, 32'd20, 32'd30, 32'd42, 32'd56, 32'd72, 32'd90};
    logic [7:0]   expOvf;
    int           lat;
    bit           sawValid;

    initial begin
        reset_n   = 1'b0;
        softClear = 1'b0;
        busA.in_valid = 1'b0; busA.in_data = '0; busA.in_count = '0; busA.out_ready = 1'b1;
        busB.in_valid = 1'b0; busB.in_data = '0; busB.in_count = '0; busB.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", 512'(busA.in_ready), 512'd1);
        checkOutput("rst_out_valid", 512'(busA.out_valid), 512'd0);
        checkOutput("rst_out_data", busA.out_data, 512'd0);
        checkOutput("rst_out_count", 512'(busA.out_count), 512'd0);
        checkOutput("rst_ovf", 512'(busA.ovf_mask), 512'd0);
        checkOutput("rst_busy", 512'(busyA), 512'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Single lane 3*5.
        line = '0; line = putWord(line, 0, 32'd3); line = putWord(line, 1, 32'd5);
        applyStimulus(1'b0, line, 4'd1, lat);
        checkOutput("t1_latency", 512'(lat), 512'd4);
        checkOutput("t1_data", busA.out_data, 512'd15);
        checkOutput("t1_count", 512'(busA.out_count), 512'd1);
        retire();

        // Eight lanes (i+1)*10 at full rate, then at half rate on dutB.
        line = '0; expLine = '0;
        for (int i = 0; i < 8; i++) begin
            line    = putWord(line, 2*i, 32'(i + 1));
            line    = putWord(line, 2*i + 1, 32'd10);
            expLine = putWord(expLine, i, exp10[i]);
        end
        applyStimulus(1'b0, line, 4'd8, lat);
        checkOutput("t2_latency_i1", 512'(lat), 512'd11);
        checkOutput("t2_data_i1", busA.out_data, expLine);
        checkOutput("t2_count_i1", 512'(busA.out_count), 512'd8);
        retire();
        applyStimulus(1'b1, line, 4'd8, lat);
        checkOutput("t2_latency_i2", 512'(lat), 512'd18);
        checkOutput("t2_data_i2", busB.out_data, expLine);
        checkOutput("t2_count_i2", 512'(busB.out_count), 512'd8);
        retire();

        // Empty job, then an over-range count clamped to 8 lanes.
        applyStimulus(1'b0, line, 4'd0, lat);
        checkOutput("t3_latency_zero", 512'(lat), 512'd1);
        checkOutput("t3_data_zero", busA.out_data, 512'd0);
        checkOutput("t3_count_zero", 512'(busA.out_count), 512'd0);
        retire();
        line = '0; expLine = '0;
        for (int i = 0; i < 8; i++) begin
            line    = putWord(line, 2*i, 32'(i + 2));
            line    = putWord(line, 2*i + 1, 32'(i + 3));
            expLine = putWord(expLine, i, exp9[i]);
        end
        applyStimulus(1'b0, line, 4'd9, lat);
        checkOutput("t3_latency_clamp", 512'(lat), 512'd11);
        checkOutput("t3_data_clamp", busA.out_data, expLine);
        checkOutput("t3_count_clamp", 512'(busA.out_count), 512'd8);
        retire();

        // Back-pressure in OUTPUT with a second job waiting on the input.
        line = '0; line = putWord(line, 0, 32'd2); line = putWord(line, 1, 32'd3);
        line = putWord(line, 2, 32'd4); line = putWord(line, 3, 32'd5);
        expLine = '0; expLine = putWord(expLine, 0, 32'd6); expLine = putWord(expLine, 1, 32'd20);
        busA.out_ready = 1'b0;
        applyStimulus(1'b0, line, 4'd2, lat);
        checkOutput("t4_latency", 512'(lat), 512'd5);
        line2 = '0; line2 = putWord(line2, 0, 32'd6); line2 = putWord(line2, 1, 32'd7);
        busA.in_data = line2; busA.in_count = 4'd1; busA.in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            checkOutput("t4_hold_data", busA.out_data, expLine);
            checkOutput("t4_hold_valid", 512'(busA.out_valid), 512'd1);
            checkOutput("t4_hold_in_ready", 512'(busA.in_ready), 512'd0);
            checkOutput("t4_hold_count", 512'(busA.out_count), 512'd2);
            @(posedge clk); #1;
        end
        busA.out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("t4_release_valid", 512'(busA.out_valid), 512'd0);
        checkOutput("t4_release_in_ready", 512'(busA.in_ready), 512'd1);
        applyStimulus(1'b0, line2, 4'd1, lat);
        checkOutput("t4_second_latency", 512'(lat), 512'd4);
        checkOutput("t4_second_data", busA.out_data, 512'd42);
        checkOutput("t4_second_count", 512'(busA.out_count), 512'd1);
        retire();

        // soft_clear after three lanes have been issued.
        line = '0;
        for (int i = 0; i < 8; i++) begin
            line = putWord(line, 2*i, 32'(i + 1));
            line = putWord(line, 2*i + 1, 32'd10);
        end
        busA.in_data = line; busA.in_count = 4'd8; busA.in_valid = 1'b1;
        @(posedge clk); #1;
        busA.in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        softClear = 1'b1;
        @(posedge clk); #1;
        softClear = 1'b0;
        checkOutput("t5_clear_in_ready", 512'(busA.in_ready), 512'd1);
        checkOutput("t5_clear_busy", 512'(busyA), 512'd0);
        checkOutput("t5_clear_out_valid", 512'(busA.out_valid), 512'd0);
        checkOutput("t5_clear_count", 512'(busA.out_count), 512'd0);
        checkOutput("t5_clear_data", busA.out_data, 512'd0);
        sawValid = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            if (busA.out_valid) sawValid = 1'b1;
        end
        checkOutput("t5_no_out_valid", 512'(sawValid), 512'd0);
        line = '0; line = putWord(line, 0, 32'd3); line = putWord(line, 1, 32'd7);
        applyStimulus(1'b0, line, 4'd1, lat);
        checkOutput("t5_after_latency", 512'(lat), 512'd4);
        checkOutput("t5_after_data", busA.out_data, 512'd21);
        retire();

        // Overflowing lane 0 plus an ordinary lane 1.
        line = '0;
        line = putWord(line, 0, 32'h0001_0000); line = putWord(line, 1, 32'h0001_0000);
        line = putWord(line, 2, 32'd2);         line = putWord(line, 3, 32'd3);
        expLine = '0; expLine = putWord(expLine, 1, 32'd6);
`ifdef MULT_BATCH_OVF_EN
        expOvf = 8'h01;
`else
        expOvf = 8'h00;
`endif
        applyStimulus(1'b0, line, 4'd2, lat);
        checkOutput("t6_latency", 512'(lat), 512'd5);
        checkOutput("t6_data", busA.out_data, expLine);
        checkOutput("t6_ovf", 512'(busA.ovf_mask), 512'(expOvf));
        retire();

        // Asynchronous reset while draining.
        line = '0; line = putWord(line, 0, 32'd5); line = putWord(line, 1, 32'd6);
        line = putWord(line, 2, 32'd7); line = putWord(line, 3, 32'd8);
        busA.in_data = line; busA.in_count = 4'd2; busA.in_valid = 1'b1;
        @(posedge clk); #1;
        busA.in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        checkOutput("t7_pre_busy", 512'(busyA), 512'd1);
        checkOutput("t7_pre_data", busA.out_data, 512'd30);
        reset_n = 1'b0;
        #1;
        checkOutput("t7_rst_data", busA.out_data, 512'd0);
        checkOutput("t7_rst_in_ready", 512'(busA.in_ready), 512'd1);
        checkOutput("t7_rst_out_valid", 512'(busA.out_valid), 512'd0);
        checkOutput("t7_rst_busy", 512'(busyA), 512'd0);
        checkOutput("t7_rst_count", 512'(busA.out_count), 512'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
